// File: rtl/dtmf_digit_sequencer_pkg.sv
// Shared types and constants for the DTMF digit sequencer: FSM states,
// row/column tone indices and a key-code-to-character lookup.
package dtmf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } dtmf_state_t;

  localparam logic [1:0] ROW_697  = 2'd0;
  localparam logic [1:0] ROW_770  = 2'd1;
  localparam logic [1:0] ROW_852  = 2'd2;
  localparam logic [1:0] ROW_941  = 2'd3;
  localparam logic [1:0] COL_1209 = 2'd0;
  localparam logic [1:0] COL_1336 = 2'd1;
  localparam logic [1:0] COL_1477 = 2'd2;
  localparam logic [1:0] COL_1633 = 2'd3;

  function automatic logic [7:0] key_char(input logic [3:0] code);
    logic [7:0] c;
    case (code)
      4'h0: c = "1";  4'h1: c = "2";  4'h2: c = "3";  4'h3: c = "A";
      4'h4: c = "4";  4'h5: c = "5";  4'h6: c = "6";  4'h7: c = "B";
      4'h8: c = "7";  4'h9: c = "8";  4'hA: c = "9";  4'hB: c = "C";
      4'hC: c = "*";  4'hD: c = "0";  4'hE: c = "#";  default: c = "D";
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dtmf_digit_sequencer_duration_counter.sv
// Loadable down-counter timing the TONE and GAP phases; saturates at zero.
module dtmf_duration_counter #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dtmf_digit_sequencer.sv
// DTMF digit sequencer: gates the selected row/column tones for a burst, then a gap.
// Optional abort input enabled by defining DTMF_ABORT_EN.
module dtmf_digit_sequencer
  import dtmf_pkg::*;
#(
  parameter int unsigned TONE_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES  = 50000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       inclk,
  input  logic       reset_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
`ifdef DTMF_ABORT_EN
  input  logic       abort,
`endif
  output logic       key_ready,
  input  logic [3:0] row_tones,
  input  logic [3:0] col_tones,
  output logic       row_out,
  output logic       col_out,
  output logic [1:0] tone_out,
  output logic       busy,
  output logic       digit_done
);

  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  dtmf_state_t state;
  logic [1:0]  row;
  logic [1:0]  col;
  logic [1:0]  row_sel;
  logic [1:0]  col_sel;
  logic        kill;
  logic        accept;
  logic        zero;
  logic        cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic        row_bit;
  logic        col_bit;

`ifdef DTMF_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign key_ready  = (state == IDLE) && !kill;
  assign accept     = key_valid && key_ready;
  assign busy       = (state != IDLE);
  assign digit_done = (state == GAP) && zero && !kill;

  // On the accept edge the latches are not loaded yet, so select from key_code
  // directly; this gives the first tone sample in the first TONE cycle.
  assign row_sel = (state == IDLE) ? key_code[3:2] : row;
  assign col_sel = (state == IDLE) ? key_code[1:0] : col;
  assign row_bit = row_tones[row_sel];
  assign col_bit = col_tones[col_sel];

  assign cnt_load  = accept || ((state == TONE) && zero && !kill);
  assign cnt_value = (state == IDLE) ? TONE_LOAD : GAP_LOAD;

  dtmf_duration_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (inclk),
    .rst_n      (reset_n),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (busy),
    .zero       (zero)
  );

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      row_out  <= 1'b0;
      col_out  <= 1'b0;
      tone_out <= '0;
    end else begin
      row_out  <= 1'b0;
      col_out  <= 1'b0;
      tone_out <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= TONE;
            row      <= key_code[3:2];
            col      <= key_code[1:0];
            row_out  <= row_bit;
            col_out  <= col_bit;
            tone_out <= {1'b0, row_bit} + {1'b0, col_bit};
          end
        end
        TONE: begin
          if (kill) begin
            state <= IDLE;
          end else if (zero) begin
            state <= GAP;
          end else begin
            row_out  <= row_bit;
            col_out  <= col_bit;
            tone_out <= {1'b0, row_bit} + {1'b0, col_bit};
          end
        end
        GAP: begin
          if (kill || zero) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtmf_digit_sequencer.sv
// Bench for dtmf_digit_sequencer: two instances (20/10 and 1/1 cycle timing)
// checked every cycle against a cycle-offset model, plus literal spot checks.
module tb_dtmf_digit_sequencer;
  import dtmf_pkg::*;

  localparam int unsigned T0 = 20;
  localparam int unsigned G0 = 10;
  localparam int unsigned T1 = 1;
  localparam int unsigned G1 = 1;
`ifdef DTMF_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic       inclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic       abort_v = 1'b0;
  logic [3:0] row_tones = '0;
  logic [3:0] col_tones = '0;
  logic [1:0] ready_o, row_o, col_o, busy_o, done_o;
  logic [1:0] tone_o [2];
  logic       abort_eff;
  bit         rand_tones = 1'b1;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  assign abort_eff = ABORT_ON && abort_v;

  always #5 inclk = ~inclk;
  always @(posedge inclk) cyc <= cyc + 1;

  dtmf_digit_sequencer #(.TONE_CYCLES(T0), .GAP_CYCLES(G0), .CNT_W(17)) dut0 (
    .inclk(inclk), .reset_n(reset_n), .key_code(key_code), .key_valid(key_valid),
`ifdef DTMF_ABORT_EN
    .abort(abort_v),
`endif
    .key_ready(ready_o[0]), .row_tones(row_tones), .col_tones(col_tones),
    .row_out(row_o[0]), .col_out(col_o[0]), .tone_out(tone_o[0]),
    .busy(busy_o[0]), .digit_done(done_o[0])
  );

  dtmf_digit_sequencer #(.TONE_CYCLES(T1), .GAP_CYCLES(G1), .CNT_W(17)) dut1 (
    .inclk(inclk), .reset_n(reset_n), .key_code(key_code), .key_valid(key_valid),
`ifdef DTMF_ABORT_EN
    .abort(abort_v),
`endif
    .key_ready(ready_o[1]), .row_tones(row_tones), .col_tones(col_tones),
    .row_out(row_o[1]), .col_out(col_o[1]), .tone_out(tone_o[1]),
    .busy(busy_o[1]), .digit_done(done_o[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge inclk) begin
    #1;
    if (rand_tones) begin
      row_tones = 4'($urandom);
      col_tones = 4'($urandom);
    end
  end

  // Model: a digit accepted in cycle N plays tones in N+1..N+T (each output
  // showing the previous cycle's tone input), is silent in N+T+1..N+T+G, and
  // reports done in N+T+G.
  bit          act [2];
  int unsigned start [2];
  logic [1:0]  mrow [2];
  logic [1:0]  mcol [2];
  logic [3:0]  prev_r = '0;
  logic [3:0]  prev_c = '0;

  always @(negedge inclk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int unsigned tc = (i == 0) ? T0 : T1;
      automatic int unsigned gc = (i == 0) ? G0 : G1;
      automatic int unsigned d  = cyc - start[i];
      automatic int er = 0, ec = 0, eb = 0, ed = 0;
      automatic int ek = abort_eff ? 0 : 1;
      if (act[i] && reset_n) begin
        eb = 1;
        ek = 0;
        if (d <= tc) begin
          er = int'(prev_r[mrow[i]]);
          ec = int'(prev_c[mcol[i]]);
        end else begin
          ed = ((d == tc + gc) && !abort_eff) ? 1 : 0;
        end
      end
      check($sformatf("row_out[%0d]", i), int'(row_o[i]), er);
      check($sformatf("col_out[%0d]", i), int'(col_o[i]), ec);
      check($sformatf("tone_out[%0d]", i), int'(tone_o[i]), er + ec);
      check($sformatf("busy[%0d]", i), int'(busy_o[i]), eb);
      check($sformatf("digit_done[%0d]", i), int'(done_o[i]), ed);
      check($sformatf("key_ready[%0d]", i), int'(ready_o[i]), ek);
      if (!reset_n) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        if ((d == tc + gc) || abort_eff) act[i] = 1'b0;
      end else if (key_valid && !abort_eff) begin
        act[i]   = 1'b1;
        start[i] = cyc;
        mrow[i]  = key_code[3:2];
        mcol[i]  = key_code[1:0];
      end
    end
    prev_r = row_tones;
    prev_c = col_tones;
  end

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && ready_o != 2'b11; k++) step();
    check("wait_idle", int'(ready_o), 3);
  endtask

  initial begin
    int unsigned n, a1, a2;
    repeat (3) @(posedge inclk);
    #1;
    check("reset busy0", int'(busy_o[0]), 0);
    check("reset tone0", int'(tone_o[0]), 0);
    reset_n = 1'b1;
    step();
    check("ready after reset", int'(ready_o[0]), 1);

    // Digit '5': done exactly T0+G0 cycles after acceptance, ready next cycle
    wait_idle();
    key_code = 4'h5; key_valid = 1'b1; n = cyc;
    step();
    key_valid = 1'b0;
    for (int k = 0; k < 40 && !done_o[0]; k++) step();
    check("digit5 done offset", int'(cyc - n), 30);
    step();
    check("digit5 ready after done", int'(ready_o[0]), 1);

    // Held key_valid: 0x0 then 0xF back to back
    wait_idle();
    key_code = 4'h0; key_valid = 1'b1; a1 = cyc;
    step();
    key_code = 4'hF;
    for (int k = 0; k < 60 && !ready_o[0]; k++) step();
    a2 = cyc;
    check($sformatf("b2b spacing key %c", key_char(4'hF)), int'(a2 - a1), 31);
    step();
    key_valid = 1'b0;
    check("b2b second busy", int'(busy_o[0]), 1);

    // Forced tones: both selected tones high, then both low
    wait_idle();
    rand_tones = 1'b0;
    row_tones = 4'b0001 << ROW_697; col_tones = 4'b0001 << COL_1209;
    key_code = 4'h0; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("forced tone_out 2", int'(tone_o[0]), 2);
      step();
    end
    check("forced gap tone_out", int'(tone_o[0]), 0);
    row_tones = '0; col_tones = '0;
    wait_idle();
    key_code = 4'h0; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("forced low busy", int'(busy_o[0]), 1);
    check("forced low tone_out", int'(tone_o[0]), 0);
    rand_tones = 1'b1;

    // Reset at TONE cycle 7
    wait_idle();
    rand_tones = 1'b0;
    row_tones = 4'hF; col_tones = 4'hF;
    key_code = 4'h5; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (6) step();
    check("pre-reset tone_out", int'(tone_o[0]), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset row_out", int'(row_o[0]), 0);
    check("async reset tone_out", int'(tone_o[0]), 0);
    check("async reset busy", int'(busy_o[0]), 0);
    rand_tones = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
    check("ready after mid-burst reset", int'(ready_o[0]), 1);

`ifdef DTMF_ABORT_EN
    wait_idle();
    key_code = 4'h5; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (T0 + 2) step();
    check("abort pre busy", int'(busy_o[0]), 1);
    abort_v = 1'b1;
    step();
    abort_v = 1'b0;
    check("abort -> idle", int'(busy_o[0]), 0);
    abort_v = 1'b1; key_valid = 1'b1;
    #1;
    check("abort masks ready", int'(ready_o[0]), 0);
    step();
    check("abort blocks accept", int'(busy_o[0]), 0);
    abort_v = 1'b0; key_valid = 1'b0;
`endif

    // Shortest timing instance: tone, gap+done, idle
    wait_idle();
    key_code = 4'hD; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("t1 tone busy", int'(busy_o[1]), 1);
    check("t1 tone no done", int'(done_o[1]), 0);
    step();
    check("t1 gap done", int'(done_o[1]), 1);
    step();
    check("t1 idle ready", int'(ready_o[1]), 1);
    check("t1 idle busy", int'(busy_o[1]), 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      key_valid = ($urandom_range(0, 3) != 0);
      key_code  = 4'($urandom);
      abort_v   = ABORT_ON && ($urandom_range(0, 99) == 0);
      reset_n   = ($urandom_range(0, 999) != 0);
      step();
    end
    reset_n = 1'b1; key_valid = 1'b0; abort_v = 1'b0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
